multicycle_ctrl: RTL

Parametrised multicycle main controller for the MIPS-subset core. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It stalls on a memory-ready handshake, optionally supports BNE, and traps on illegal opcodes. It sits between the instruction register opcode field and the shared-memory multicycle datapath.

---
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller for the MIPS-subset core: sequences fetch, decode,
// execute, memory and writeback, stalls on mem_ready and traps on illegal opcodes.
module multicycle_ctrl #(
   parameter int OP_W    = 6,
   parameter bit EN_BNE  = 1'b1,
   parameter bit EN_WAIT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            iord,
   output logic            memwrite,
   output logic            irwrite,
   output logic            pcwrite,
   output logic            branch,
   output logic            branch_ne,
   output logic [1:0]      pcsrc,
   output logic            alusrca,
   output logic [1:0]      alusrcb,
   output logic [1:0]      aluop,
   output logic            regdst,
   output logic            memtoreg,
   output logic            regwrite,
   output logic            illegal,
   output logic [3:0]      state
);

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd15
   } state_t;

   state_t cur;
   logic   ready;

   assign ready = EN_WAIT ? mem_ready : 1'b1;
   assign state = cur;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur <= S_FETCH;
      end else begin
         case (cur)
            S_FETCH:  if (ready) cur <= S_DECODE;
            S_DECODE: begin
               if (op == OP_RTYPE)                  cur <= S_EXEC;
               else if (op == OP_LW || op == OP_SW) cur <= S_MEMADR;
               else if (op == OP_BEQ)               cur <= S_BRANCH;
               else if (op == OP_BNE)               cur <= EN_BNE ? S_BRANCH : S_TRAP;
               else if (op == OP_ADDI)              cur <= S_ADDIEX;
               else if (op == OP_J)                 cur <= S_JUMP;
               else                                 cur <= S_TRAP;
            end
            S_MEMADR: begin
               if (op == OP_LW)      cur <= S_MEMRD;
               else if (op == OP_SW) cur <= S_MEMWR;
               else                  cur <= S_TRAP;
            end
            S_MEMRD:  if (ready) cur <= S_MEMWB;
            S_MEMWB:  cur <= S_FETCH;
            S_MEMWR:  if (ready) cur <= S_FETCH;
            S_EXEC:   cur <= S_ALUWB;
            S_ALUWB:  cur <= S_FETCH;
            S_BRANCH: cur <= S_FETCH;
            S_ADDIEX: cur <= S_ADDIWB;
            S_ADDIWB: cur <= S_FETCH;
            S_JUMP:   cur <= S_FETCH;
            S_TRAP:   cur <= S_TRAP;
            default:  cur <= S_TRAP;
         endcase
      end
   end

   // NOTE: every output gets a default first, so no path through the case
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      iord      = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;
      pcsrc     = 2'b00;
      alusrca   = 1'b0;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      regdst    = 1'b0;
      memtoreg  = 1'b0;
      regwrite  = 1'b0;
      illegal   = 1'b0;
      case (cur)
         S_FETCH: begin
            alusrcb = 2'b01;
            irwrite = ready;
            pcwrite = ready;
         end
         S_DECODE: alusrcb = 2'b11;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         S_BRANCH: begin
            alusrca   = 1'b1;
            aluop     = 2'b01;
            pcsrc     = 2'b01;
            branch    = (op == OP_BEQ);
            branch_ne = (op == OP_BNE);
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite = 1'b1;
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         S_TRAP:  illegal = 1'b1;
         default: illegal = 1'b1;
      endcase
      // Strobes stay quiet while reset is asserted so an abandoned
      // instruction cannot write anything on its way out.
      if (!rst_n) begin
         memwrite  = 1'b0;
         irwrite   = 1'b0;
         pcwrite   = 1'b0;
         branch    = 1'b0;
         branch_ne = 1'b0;
         regwrite  = 1'b0;
      end
   end

endmodule
